zero_count_unit: RTL and testbench

Iterative count-leading-zeros / count-trailing-zeros unit for the Zbb bit-manipulation path. It complements the combinational population-count block by counting zeros from either end of an operand. It sits beside the ALU as a multi-cycle functional unit with valid/ready handshakes on both sides. The operand is scanned BITS_PER_CYCLE bits per clock with early termination, trading latency for area against a full priority encoder.

---
 rtl/zero_count_unit.sv | 142 ++++++++++++++
 tb/tb_zero_count_unit.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/zero_count_unit.sv
// Iterative count-leading-zeros / count-trailing-zeros unit.
// Scans BITS_PER_CYCLE bits per clock from the MSB end of a working register.
// When no set bit is found, the count keeps growing up to DATA_WIDTH.
// ctz is handled by bit-reversing the operand at accept time.
module zero_count_unit #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned BITS_PER_CYCLE = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  op,
    input  logic [DATA_WIDTH-1:0] operand,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  busy
);

    localparam int unsigned NCHUNK = DATA_WIDTH / BITS_PER_CYCLE;
    localparam int unsigned CW     = $clog2(DATA_WIDTH + 1);
    localparam int unsigned IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic                    alive;
    logic [DATA_WIDTH-1:0]   work;
    logic [DATA_WIDTH-1:0]   operand_rev;
    logic [CW-1:0]           count;
    logic [CW-1:0]           chunk_lz;
    logic [IW-1:0]           chunk_idx;
    logic [BITS_PER_CYCLE-1:0] chunk;
    logic                    chunk_zero;
    logic                    last_chunk;
    logic                    accept;

    // Bit-reverse the operand so ctz can reuse the MSB-first scan.
    always_comb begin
        operand_rev = '0;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            operand_rev[i] = operand[DATA_WIDTH-1-i];
        end
    end

    // Examine the top chunk of the working register: all-zero flag and leading-zero count.
    always_comb begin
        logic found;
        chunk      = work[DATA_WIDTH-1 -: BITS_PER_CYCLE];
        chunk_zero = (chunk == '0);
        last_chunk = (chunk_idx == IW'(NCHUNK - 1));
        chunk_lz   = '0;
        found      = 1'b0;
        for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
            if (!found && chunk[BITS_PER_CYCLE-1-i]) begin
                found    = 1'b1;
                chunk_lz = CW'(i);
            end
        end
    end

    // State register; alive holds in_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            alive <= 1'b0;
        end else begin
            state <= state_next;
            alive <= 1'b1;
        end
    end

    // Next-state and output decode, driven from registered state only.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        result     = '0;
        case (state)
            IDLE: begin
                in_ready = alive;
                if (in_valid && alive) begin
                    state_next = SCAN;
                end
            end
            SCAN: begin
                busy = 1'b1;
                if (!chunk_zero || last_chunk) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                result    = DATA_WIDTH'(count);
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept = in_valid && in_ready;

    // Datapath: load on accept, then accumulate the count chunk by chunk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work      <= '0;
            count     <= '0;
            chunk_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        work      <= op ? operand_rev : operand;
                        count     <= '0;
                        chunk_idx <= '0;
                    end
                end
                SCAN: begin
                    if (chunk_zero) begin
                        count     <= count + CW'(BITS_PER_CYCLE);
                        work      <= work << BITS_PER_CYCLE;
                        chunk_idx <= chunk_idx + IW'(1);
                    end else begin
                        count <= count + chunk_lz;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_zero_count_unit.sv
// Directed bench for zero_count_unit with a scoreboard of expected result/latency.
module tb_zero_count_unit;

    localparam int unsigned DW  = 32;
    localparam int unsigned BPC = 4;
    localparam int unsigned NCH = DW / BPC;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          in_valid = 1'b0;
    logic          op = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] operand = '0;
    logic          in_ready;
    logic          out_valid;
    logic          busy;
    logic [DW-1:0] result;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [DW-1:0] res;
        int            lat;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    zero_count_unit #(
        .DATA_WIDTH    (DW),
        .BITS_PER_CYCLE(BPC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .operand  (operand),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .busy     (busy)
    );

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_count(input logic o, input logic [DW-1:0] x);
        int c = 0;
        for (int i = 0; i < int'(DW); i++) begin
            if (x[o ? i : int'(DW) - 1 - i]) break;
            c++;
        end
        return c;
    endfunction

    function automatic int ref_lat(input int c);
        if (c >= int'(DW)) return int'(NCH);
        return c / int'(BPC) + 1;
    endfunction

    // One transaction: accept, wait for result, optional backpressure / ignored pokes, handshake.
    task automatic run_op(input logic o, input logic [DW-1:0] val, input int hold, input bit poke);
        exp_t e;
        int   cyc;
        check("in_ready_idle", in_ready, 1);
        e.res = ref_count(o, val);
        e.lat = ref_lat(e.res);
        sb.push_back(e);
        op       = o;
        operand  = val;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        operand  = $urandom;
        cyc      = 0;
        while (!out_valid && cyc < 20) begin
            if (poke) begin
                in_valid = 1'b1;
                op       = 1'($urandom_range(0, 1));
                operand  = $urandom;
            end
            check("busy_scan", busy, 1);
            check("in_ready_scan", in_ready, 0);
            @(negedge clk);
            cyc++;
        end
        check("out_valid_timeout", out_valid, 1);
        e = sb.pop_front();
        check("result", result, e.res);
        check("latency", cyc, e.lat);
        check("in_ready_done", in_ready, 0);
        repeat (hold) begin
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_result", result, e.res);
            check("hold_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("post_valid", out_valid, 0);
        check("post_result", result, 0);
        check("post_in_ready", in_ready, 1);
        check("post_busy", busy, 0);
    endtask

    initial begin
        logic [DW-1:0] rv;
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_result", result, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("release_in_ready", in_ready, 1);

        run_op(1'b0, 32'h8000_0000, 0, 1'b0);
        run_op(1'b0, 32'h0000_0001, 5, 1'b1);
        run_op(1'b1, 32'h0000_0100, 0, 1'b0);
        run_op(1'b1, 32'h8000_0000, 0, 1'b0);
        run_op(1'b0, 32'h0000_0000, 0, 1'b0);
        run_op(1'b1, 32'h0000_0000, 2, 1'b1);
        run_op(1'b0, 32'h0F00_0000, 0, 1'b0);
        run_op(1'b1, 32'hFFFF_FFFF, 0, 1'b0);
        for (int n = 0; n < 12; n++) begin
            rv = $urandom >> $urandom_range(0, 31);
            run_op(1'($urandom_range(0, 1)), rv, n % 3, 1'($urandom_range(0, 1)));
        end

        // Abort clz(1) during its 4th SCAN cycle.
        op       = 1'b0;
        operand  = 32'h0000_0001;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_abort_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_in_ready", in_ready, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_result", result, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            check("no_stale_valid", out_valid, 0);
            check("no_stale_in_ready", in_ready, 1);
        end
        run_op(1'b0, 32'h00F0_0000, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
